// File: rtl/bram_stream_reader.sv
// bram_stream_reader: reads LEN consecutive 32-bit words from a BRAM port and emits them as a valid/ready stream.
// Latency: first M_VALID READ_LATENCY+2 cycles after START; one word per cycle sustained with M_READY high.
// Backpressure: M_READY low fills the output FIFO; reads stall once FIFO occupancy plus in-flight reads reach FIFO_DEPTH.

// Small generic FIFO; the caller guarantees no write when full.
module stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   core_clk,
  input  logic                   arst_n,
  input  logic                   wr_vld,
  input  logic [WIDTH-1:0]       wr_dat,
  output logic                   rd_vld,
  input  logic                   rd_rdy,
  output logic [WIDTH-1:0]       rd_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_en;

  assign rd_vld = (count != '0);
  assign rd_en  = rd_vld && rd_rdy;
  assign rd_dat = mem[rd_ptr];

  // Storage array, written at the tail
  always_ff @(posedge core_clk) begin
    if (wr_vld) mem[wr_ptr] <= wr_dat;
  end

  // Pointers and occupancy; push and pop in one cycle leave the count unchanged
  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_vld) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({wr_vld, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module bram_stream_reader #(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int LEN_WIDTH       = 14,
  parameter int READ_LATENCY    = 2,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       BRAM_CLK,
  input  logic                       BRAM_RSTN,
  input  logic                       START,
  input  logic [BRAM_ADDR_WIDTH-1:0] BASE_ADDR,
  input  logic [LEN_WIDTH-1:0]       LEN,
  output logic                       BUSY,
  output logic                       DONE,
  output logic [BRAM_ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic                       BRAM_EN,
  output logic [3:0]                 BRAM_WE,
  output logic [31:0]                BRAM_WRDATA,
  input  logic [31:0]                BRAM_RDDATA,
  output logic [31:0]                M_DATA,
  output logic                       M_VALID,
  input  logic                       M_READY,
  output logic                       M_LAST
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]       issue_cnt;
  logic [LEN_WIDTH-1:0]       beat_cnt;
  logic [READ_LATENCY-1:0]    tag_sr;
  logic [CW-1:0]              inflight_cnt;
  logic [CW-1:0]              fifo_cnt;
  logic [CW:0]                credit_used;
  logic                       issue;
  logic                       rsp_vld;
  logic                       beat_xfer;
  logic                       start_ok;
  logic                       unused_base_lsb;

  // Word-aligned reads only; the byte offset bits carry no information
  assign unused_base_lsb = ^BASE_ADDR[1:0];

  assign BRAM_WE     = 4'b0000;
  assign BRAM_WRDATA = 32'h0;
  assign BRAM_ADDR   = addr_q;

  // Credit counts words already buffered plus reads whose data is still in the BRAM pipe
  assign credit_used = {1'b0, fifo_cnt} + {1'b0, inflight_cnt};
  assign issue       = (state == RUN) && (issue_cnt != '0) &&
                       (credit_used < (CW+1)'(FIFO_DEPTH));
  assign rsp_vld     = tag_sr[READ_LATENCY-1];
  assign beat_xfer   = M_VALID && M_READY;
  assign start_ok    = (state == IDLE) && START && (LEN != '0);
  assign M_LAST      = M_VALID && (beat_cnt == LEN_WIDTH'(1));

  // State register
  always_ff @(posedge BRAM_CLK or negedge BRAM_RSTN) begin
    if (!BRAM_RSTN) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next state and control outputs; FIN is entered as the last beat leaves
  always_comb begin
    state_nxt = state;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    BRAM_EN   = 1'b0;
    case (state)
      IDLE: begin
        if (START) state_nxt = (LEN != '0) ? RUN : FIN;
      end
      RUN: begin
        BUSY    = 1'b1;
        BRAM_EN = issue;
        if (issue && (issue_cnt == LEN_WIDTH'(1))) state_nxt = DRAIN;
      end
      DRAIN: begin
        BUSY = 1'b1;
        if ((beat_cnt == '0) || ((beat_cnt == LEN_WIDTH'(1)) && beat_xfer))
          state_nxt = FIN;
      end
      FIN: begin
        DONE      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address and transfer counters
  always_ff @(posedge BRAM_CLK or negedge BRAM_RSTN) begin
    if (!BRAM_RSTN) begin
      addr_q    <= '0;
      issue_cnt <= '0;
      beat_cnt  <= '0;
    end else if (start_ok) begin
      addr_q    <= {BASE_ADDR[BRAM_ADDR_WIDTH-1:2], 2'b00};
      issue_cnt <= LEN;
      beat_cnt  <= LEN;
    end else begin
      if (issue) begin
        addr_q    <= addr_q + BRAM_ADDR_WIDTH'(4);
        issue_cnt <= issue_cnt - 1'b1;
      end
      if (beat_xfer) beat_cnt <= beat_cnt - 1'b1;
    end
  end

  // In-flight read tags; the tag leaving the top marks BRAM_RDDATA as valid
  always_ff @(posedge BRAM_CLK or negedge BRAM_RSTN) begin
    if (!BRAM_RSTN) begin
      tag_sr       <= '0;
      inflight_cnt <= '0;
    end else begin
      tag_sr <= READ_LATENCY'({tag_sr, issue});
      case ({issue, rsp_vld})
        2'b10:   inflight_cnt <= inflight_cnt + 1'b1;
        2'b01:   inflight_cnt <= inflight_cnt - 1'b1;
        default: inflight_cnt <= inflight_cnt;
      endcase
    end
  end

  stream_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .core_clk (BRAM_CLK),
    .arst_n   (BRAM_RSTN),
    .wr_vld   (rsp_vld),
    .wr_dat   (BRAM_RDDATA),
    .rd_vld   (M_VALID),
    .rd_rdy   (M_READY),
    .rd_dat   (M_DATA),
    .count    (fifo_cnt)
  );
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: scoreboard bench for bram_stream_reader with a 2-cycle BRAM model.
// Latency: expected words queued at START, compared as beats leave the stream port.
// Backpressure: M_READY driven always-high or in a 1,0,0,1 pattern.

module tb_bram_stream_reader;
  localparam int AW    = 15;
  localparam int LW    = 14;
  localparam int DEPTH = 4;

  logic          BRAM_CLK;
  logic          BRAM_RSTN;
  logic          START;
  logic [AW-1:0] BASE_ADDR;
  logic [LW-1:0] LEN;
  logic          BUSY;
  logic          DONE;
  logic [AW-1:0] BRAM_ADDR;
  logic          BRAM_EN;
  logic [3:0]    BRAM_WE;
  logic [31:0]   BRAM_WRDATA;
  logic [31:0]   BRAM_RDDATA;
  logic [31:0]   M_DATA;
  logic          M_VALID;
  logic          M_READY;
  logic          M_LAST;

  bram_stream_reader #(
    .BRAM_ADDR_WIDTH (AW),
    .LEN_WIDTH       (LW),
    .READ_LATENCY    (2),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .BRAM_CLK    (BRAM_CLK),
    .BRAM_RSTN   (BRAM_RSTN),
    .START       (START),
    .BASE_ADDR   (BASE_ADDR),
    .LEN         (LEN),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .BRAM_ADDR   (BRAM_ADDR),
    .BRAM_EN     (BRAM_EN),
    .BRAM_WE     (BRAM_WE),
    .BRAM_WRDATA (BRAM_WRDATA),
    .BRAM_RDDATA (BRAM_RDDATA),
    .M_DATA      (M_DATA),
    .M_VALID     (M_VALID),
    .M_READY     (M_READY),
    .M_LAST      (M_LAST)
  );

  initial BRAM_CLK = 1'b0;
  always #5 BRAM_CLK = ~BRAM_CLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge BRAM_CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // BRAM model: data for an issue cycle appears two cycles later
  logic [31:0] mem [0:8191];
  logic [31:0] rd_s1;
  initial for (int i = 0; i < 8192; i++) mem[i] = i;
  always @(posedge BRAM_CLK) begin
    rd_s1       <= BRAM_EN ? mem[BRAM_ADDR[AW-1:2]] : 32'hDEAD_BEEF;
    BRAM_RDDATA <= rd_s1;
  end

  // Scoreboard queues and per-test statistics
  logic [32:0]   exp_q[$];
  logic [AW-1:0] addr_q[$];
  int n_issue, n_beat, n_done, n_vld;
  int first_issue, last_issue, first_beat, last_beat, done_cyc;
  int out_cnt;
  logic        hold_prev;
  logic [31:0] hold_dat;
  logic        hold_last;

  task automatic clear_stats();
    n_issue = 0; n_beat = 0; n_done = 0; n_vld = 0;
    first_issue = -1; last_issue = -1; first_beat = -1; last_beat = -1; done_cyc = -1;
  endtask

  // Monitor: address order, data order, credit limit, stability under stall
  always @(negedge BRAM_CLK) begin
    if (!BRAM_RSTN) begin
      out_cnt   = 0;
      hold_prev = 1'b0;
    end else begin
      logic [63:0] e;
      if (hold_prev) begin
        chk("hold_valid", M_VALID, 1);
        chk("hold_data", M_DATA, hold_dat);
        chk("hold_last", M_LAST, hold_last);
      end
      if (BRAM_EN) begin
        n_issue++;
        if (first_issue < 0) first_issue = cyc;
        last_issue = cyc;
        chk("credit", out_cnt + 1, (out_cnt + 1 <= DEPTH) ? out_cnt + 1 : DEPTH);
        e = (addr_q.size() != 0) ? 64'(addr_q.pop_front()) : 64'hFFFF_FFFF;
        chk("bram_addr", BRAM_ADDR, e);
        out_cnt++;
      end
      if (M_VALID) n_vld++;
      if (M_VALID && M_READY) begin
        logic [32:0] w;
        n_beat++;
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
        w = (exp_q.size() != 0) ? exp_q.pop_front() : {1'b0, 32'hBAD0_BAD0};
        chk("m_data", M_DATA, w[31:0]);
        chk("m_last", M_LAST, w[32]);
        out_cnt--;
      end
      if (DONE) begin
        n_done++;
        done_cyc = cyc;
      end
      hold_prev = M_VALID && !M_READY;
      hold_dat  = M_DATA;
      hold_last = M_LAST;
    end
  end

  // Ready driver: mode 0 always ready, mode 1 repeating 1,0,0,1
  int rdy_mode = 0;
  int rdy_ph   = 0;
  initial begin
    M_READY = 1'b1;
    forever begin
      @(posedge BRAM_CLK);
      #1;
      if (rdy_mode == 0) M_READY = 1'b1;
      else begin
        M_READY = (rdy_ph == 0) || (rdy_ph == 3);
        rdy_ph  = (rdy_ph + 1) % 4;
      end
    end
  end

  int start_cyc;

  // Pulse START for one cycle and queue the expected addresses and words
  task automatic start_xfer(input logic [AW-1:0] base, input int len);
    logic [AW-1:0] a;
    @(posedge BRAM_CLK);
    #1;
    START     = 1'b1;
    BASE_ADDR = base;
    LEN       = LW'(len);
    start_cyc = cyc;
    a = base & 15'h7FFC;
    for (int k = 0; k < len; k++) begin
      addr_q.push_back(a);
      exp_q.push_back({(k == len - 1), mem[a[AW-1:2]]});
      a = a + 15'd4;
    end
    @(posedge BRAM_CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && n_done == 0; i++) @(posedge BRAM_CLK);
    #1;
    chk(tag, n_done, 1);
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_expq"}, exp_q.size(), 0);
    chk({tag, "_addrq"}, addr_q.size(), 0);
    chk({tag, "_busy"}, BUSY, 0);
  endtask

  initial begin
    BRAM_RSTN = 1'b0;
    START     = 1'b0;
    BASE_ADDR = '0;
    LEN       = '0;
    clear_stats();
    #3;
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_en", BRAM_EN, 0);
    chk("rst_valid", M_VALID, 0);
    chk("rst_last", M_LAST, 0);
    chk("rst_addr", BRAM_ADDR, 0);
    chk("tie_we", BRAM_WE, 0);
    chk("tie_wrdata", BRAM_WRDATA, 0);
    repeat (3) @(posedge BRAM_CLK);
    #1 BRAM_RSTN = 1'b1;

    // Ramp copy with exact cycle timing
    clear_stats();
    start_xfer(15'h0000, 8);
    chk("ramp_busy", BUSY, 1);
    wait_done("ramp_done", 60);
    chk("ramp_first_issue", first_issue - start_cyc, 1);
    chk("ramp_last_issue", last_issue - start_cyc, 8);
    chk("ramp_first_beat", first_beat - start_cyc, 4);
    chk("ramp_last_beat", last_beat - start_cyc, 11);
    chk("ramp_done_cyc", done_cyc - start_cyc, 12);
    chk_drained("ramp");

    // Backpressure
    clear_stats();
    rdy_ph   = 0;
    rdy_mode = 1;
    start_xfer(15'h0200, 16);
    wait_done("bp_done", 200);
    chk("bp_beats", n_beat, 16);
    chk_drained("bp");
    rdy_mode = 0;

    // Zero length
    clear_stats();
    start_xfer(15'h0040, 0);
    wait_done("zl_done", 8);
    chk("zl_no_en", n_issue, 0);
    chk("zl_no_valid", n_vld, 0);
    chk("zl_done_dly", ((done_cyc - start_cyc) >= 1) && ((done_cyc - start_cyc) <= 2), 1);

    // Address wrap and ignored byte offset
    clear_stats();
    start_xfer(15'h7FF8, 4);
    wait_done("wrap_done", 60);
    chk_drained("wrap");
    clear_stats();
    start_xfer(15'h0006, 2);
    wait_done("unal_done", 60);
    chk_drained("unal");

    // Start while busy is ignored
    clear_stats();
    start_xfer(15'h0020, 6);
    repeat (1) @(posedge BRAM_CLK);
    #1;
    START = 1'b1; BASE_ADDR = 15'h0300; LEN = 14'd9;
    @(posedge BRAM_CLK);
    #1 START = 1'b0;
    wait_done("sb_done", 60);
    repeat (6) @(posedge BRAM_CLK);
    #1;
    chk("sb_one_done", n_done, 1);
    chk("sb_issues", n_issue, 6);
    chk_drained("sb");

    // Reset mid-run
    clear_stats();
    start_xfer(15'h0000, 10);
    for (int i = 0; i < 60 && n_beat < 3; i++) begin
      @(posedge BRAM_CLK);
      #1;
    end
    chk("mr_beats", n_beat, 3);
    BRAM_RSTN = 1'b0;
    #1;
    chk("mr_busy", BUSY, 0);
    chk("mr_valid", M_VALID, 0);
    chk("mr_en", BRAM_EN, 0);
    chk("mr_addr", BRAM_ADDR, 0);
    chk("mr_last", M_LAST, 0);
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge BRAM_CLK);
    #1 BRAM_RSTN = 1'b1;
    clear_stats();
    start_xfer(15'h0100, 2);
    wait_done("mr_new_done", 60);
    chk("mr_new_beats", n_beat, 2);
    chk_drained("mr_new");

    repeat (3) @(posedge BRAM_CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
